// File: rtl/trng_ctrl.sv
// Sequencer for the ring-oscillator TRNG: warm-up, word packing,
// valid/ready publication and repetition-count health test.
module trng_ctrl #(
  parameter int WORD_W     = 32,
  parameter int WARMUP_CYC = 64,
  parameter int RCT_CUTOFF = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [2:0]        delay_cfg_in,
  output logic              trng_enable,
  output logic [2:0]        trng_delay_cfg,
  input  logic              raw_bit,
  output logic [WORD_W-1:0] rnd_word,
  output logic              rnd_valid,
  input  logic              rnd_ready,
  output logic              busy,
  output logic              health_fail
);

  typedef enum logic [2:0] {
    IDLE,
    WARMUP,
    COLLECT,
    HOLD,
    FAIL
  } state_t;

  localparam int WW = $clog2(WARMUP_CYC + 1);
  localparam int BW = $clog2(WORD_W + 1);
  localparam int RW = $clog2(RCT_CUTOFF + 1);

  localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_CYC - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_W - 1);
  localparam logic [RW-1:0] CUTOFF    = RW'(RCT_CUTOFF);

  state_t            state;
  logic [WW-1:0]     warm_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [RW-1:0]     run_cnt;
  logic [RW-1:0]     run_next;
  logic              prev_bit;
  logic              rct_hit;
  logic [WORD_W-1:0] shreg;

  // run_cnt == 0 marks the first sample after warm-up
  always_comb begin
    run_next = RW'(1);
    if (run_cnt != '0 && raw_bit == prev_bit) begin
      if (run_cnt == CUTOFF) run_next = run_cnt;
      else                   run_next = run_cnt + 1'b1;
    end
    rct_hit = (run_next == CUTOFF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      trng_enable    <= 1'b0;
      trng_delay_cfg <= '0;
      rnd_word       <= '0;
      rnd_valid      <= 1'b0;
      busy           <= 1'b0;
      health_fail    <= 1'b0;
      warm_cnt       <= '0;
      bit_cnt        <= '0;
      run_cnt        <= '0;
      prev_bit       <= 1'b0;
      shreg          <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && !stop) begin
            state          <= WARMUP;
            trng_delay_cfg <= delay_cfg_in;
            warm_cnt       <= '0;
            trng_enable    <= 1'b1;
            busy           <= 1'b1;
          end
        end
        WARMUP, COLLECT, HOLD: begin
          if (stop) begin
            state       <= IDLE;
            trng_enable <= 1'b0;
            busy        <= 1'b0;
            rnd_valid   <= 1'b0;
            rnd_word    <= '0;
            shreg       <= '0;
            bit_cnt     <= '0;
            run_cnt     <= '0;
          end else if (state == WARMUP) begin
            if (warm_cnt == WARM_LAST) begin
              state   <= COLLECT;
              bit_cnt <= '0;
              run_cnt <= '0;
            end else begin
              warm_cnt <= warm_cnt + 1'b1;
            end
          end else begin
            prev_bit <= raw_bit;
            run_cnt  <= run_next;
            if (rct_hit) begin
              // failure beats a word completing on the same sample
              state       <= FAIL;
              health_fail <= 1'b1;
              trng_enable <= 1'b0;
              rnd_valid   <= 1'b0;
              rnd_word    <= '0;
              shreg       <= '0;
            end else if (state == COLLECT) begin
              shreg <= {shreg[WORD_W-2:0], raw_bit};
              if (bit_cnt == BIT_LAST) begin
                rnd_word  <= {shreg[WORD_W-2:0], raw_bit};
                rnd_valid <= 1'b1;
                state     <= HOLD;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else if (rnd_ready) begin
              rnd_valid <= 1'b0;
              bit_cnt   <= '0;
              state     <= COLLECT;
            end
          end
        end
        FAIL: begin
          if (stop) begin
            state       <= IDLE;
            health_fail <= 1'b0;
            busy        <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trng_ctrl.sv
// Directed bench for trng_ctrl: reset, word packing, backpressure,
// health failure, abort/restart and start/stop collision.
module tb_trng_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [2:0]  delay_cfg_in;
  logic        trng_enable;
  logic [2:0]  trng_delay_cfg;
  logic        raw_bit;
  logic [31:0] rnd_word;
  logic        rnd_valid;
  logic        rnd_ready;
  logic        busy;
  logic        health_fail;

  int checks = 0;
  int errors = 0;
  bit alt    = 1'b0;

  trng_ctrl #(
    .WORD_W    (32),
    .WARMUP_CYC(64),
    .RCT_CUTOFF(32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stop          (stop),
    .delay_cfg_in  (delay_cfg_in),
    .trng_enable   (trng_enable),
    .trng_delay_cfg(trng_delay_cfg),
    .raw_bit       (raw_bit),
    .rnd_word      (rnd_word),
    .rnd_valid     (rnd_valid),
    .rnd_ready     (rnd_ready),
    .busy          (busy),
    .health_fail   (health_fail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock; inputs change and outputs are read 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (alt) raw_bit = ~raw_bit;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // start in cycle 0; returns in cycle 1
  task automatic go(input logic [2:0] cfg, input logic raw0,
                    input bit toggle);
    delay_cfg_in = cfg;
    raw_bit      = raw0;
    alt          = toggle;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b1;
    stop         = 1'b0;
    delay_cfg_in = 3'b111;
    raw_bit      = 1'b0;
    rnd_ready    = 1'b0;

    // T1 reset, start held high under reset
    run(2);
    chk("rst_enable", trng_enable, 0);
    chk("rst_cfg",    trng_delay_cfg, 0);
    chk("rst_word",   rnd_word, 0);
    chk("rst_valid",  rnd_valid, 0);
    chk("rst_busy",   busy, 0);
    chk("rst_fail",   health_fail, 0);
    start = 1'b0;
    rst   = 1'b0;
    tick();
    chk("post_rst_busy", busy, 0);

    // T2 first word, raw=1 in cycle 65 then alternating
    go(3'b101, 1'b0, 1'b1);
    chk("t2_enable", trng_enable, 1);
    chk("t2_busy",   busy, 1);
    chk("t2_cfg",    trng_delay_cfg, 3'b101);
    run(95);
    chk("t2_valid96", rnd_valid, 0);
    tick();
    chk("t2_valid97", rnd_valid, 1);
    chk("t2_word",    rnd_word, 32'hAAAAAAAA);

    // T3 backpressure for 20 cycles, then one handshake
    for (int i = 0; i < 20; i++) begin
      chk("t3_hold_valid", rnd_valid, 1);
      chk("t3_hold_word",  rnd_word, 32'hAAAAAAAA);
      tick();
    end
    rnd_ready = 1'b1;
    tick();
    chk("t3_drop", rnd_valid, 0);
    run(31);
    chk("t3_valid149", rnd_valid, 0);
    tick();
    chk("t3_valid150", rnd_valid, 1);
    chk("t3_word2",    rnd_word, 32'h55555555);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t3_stop_busy",  busy, 0);
    chk("t3_stop_valid", rnd_valid, 0);
    chk("t3_stop_en",    trng_enable, 0);

    // T4 stuck-at-1 raw bit: 32nd sample in cycle 96 trips the RCT
    go(3'b010, 1'b1, 1'b0);
    run(95);
    chk("t4_fail96",  health_fail, 0);
    tick();
    chk("t4_fail97",  health_fail, 1);
    chk("t4_enable",  trng_enable, 0);
    chk("t4_valid",   rnd_valid, 0);
    chk("t4_word",    rnd_word, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_start_ign", health_fail, 1);
    chk("t4_start_en",  trng_enable, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t4_clear",  health_fail, 0);
    chk("t4_idle",   busy, 0);

    // T5 abort after 10 samples (cycles 65..74), stop in cycle 75
    go(3'b011, 1'b0, 1'b1);
    run(74);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t5_busy",   busy, 0);
    chk("t5_enable", trng_enable, 0);
    go(3'b100, 1'b0, 1'b1);
    chk("t5_cfg", trng_delay_cfg, 3'b100);
    run(95);
    chk("t5_valid96", rnd_valid, 0);
    tick();
    chk("t5_valid97", rnd_valid, 1);
    chk("t5_word",    rnd_word, 32'hAAAAAAAA);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // T6 start and stop together in IDLE
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("t6_busy",   busy, 0);
    chk("t6_enable", trng_enable, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
